sum_of_n_arbiter: RTL

SUM_OF_N_ARBITER -- requirements
Module: sum_of_n_arbiter

---
 rtl/sum_of_n_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/sum_of_n_arbiter.sv
// Two-requester round-robin arbiter in front of a serial 0+1+...+N accumulator.
// Grant, done and busy are registered pulses/levels; one job is in flight at a time.
module sum_of_n_arbiter #(
  parameter int N_W = 4,
  parameter int S_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N_W-1:0] n0,
  input  logic           req1,
  input  logic [N_W-1:0] n1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [S_W-1:0] s,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t         state_q, state_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic [S_W-1:0] acc_q, acc_d;
  logic [S_W-1:0] s_q, s_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic           gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic           done0_q, done0_d, done1_q, done1_d;
  logic           busy_q, busy_d;
  logic           pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    s_d     = s_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    // On a tie, serve whichever requester was not served last.
    pick    = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCUM;
          cnt_d   = pick ? n1 : n0;
          acc_d   = '0;
          owner_d = pick;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
        end
      end
      ACCUM: begin
        if (cnt_q != '0) begin
          acc_d = acc_q + S_W'(cnt_q);
          cnt_d = cnt_q - 1'b1;
        end else begin
          s_d     = acc_q;
          done0_d = ~owner_q;
          done1_d = owner_q;
          last_d  = owner_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign s     = s_q;
  assign busy  = busy_q;

endmodule
